// File: rtl/divisor_frc_pkg.sv
// divisor_frc_pkg: shared constants and helpers for the multi-channel divider
package divisor_frc_pkg;
  localparam int MIN_DIV = 2;
  localparam int DIV_1HZ = 50000000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int chw(input int ch);
    return clog2(ch) > 1 ? clog2(ch) : 1;
  endfunction
endpackage

// File: rtl/divisor_frc_multi_if.sv
// divisor_frc_multi_if: divisor load bus with single-cycle ack/err response
interface divisor_frc_multi_if
  import divisor_frc_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int CH = 2
) ();
  localparam int CHW = chw(CH);
  logic ld;
  logic [CHW-1:0] ld_ch;
  logic [WIDTH-1:0] ld_div;
  logic ld_ack;
  logic ld_err;
  modport master (output ld, ld_ch, ld_div, input ld_ack, ld_err);
  modport slave (input ld, ld_ch, ld_div, output ld_ack, ld_err);
endinterface

// File: rtl/divisor_frc_ch.sv
// divisor_frc_ch: one divider channel with a pending divisor applied glitch-free
module divisor_frc_ch #(
  parameter int WIDTH = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld,
  input  logic [WIDTH-1:0] ld_div,
  output logic clk_out,
  output logic tick
);
  logic [WIDTH-1:0] cnt, div, pending, cnt_next, nd;
  logic pend_valid, wrap;
  always_comb begin
    wrap = cnt == div - WIDTH'(1);
    cnt_next = wrap ? '0 : cnt + WIDTH'(1);
    nd = wrap && pend_valid ? pending : div;
  end
  // a new divisor only lands when cnt restarts at 0, so cnt never exceeds div-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      div <= WIDTH'(DEFAULT_DIV);
      pending <= '0;
      pend_valid <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      if (en) begin
        cnt <= cnt_next;
        div <= nd;
        clk_out <= cnt_next < (nd >> 1);
        tick <= wrap;
        if (wrap) pend_valid <= 1'b0;
      end else begin
        tick <= 1'b0;
        if (pend_valid) begin
          cnt <= '0;
          div <= pending;
          clk_out <= 1'b0;
          pend_valid <= 1'b0;
        end
      end
      if (ld) begin
        pending <= ld_div;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/divisor_frc_multi.sv
// divisor_frc_multi: CH independent clock dividers with a validated divisor load port
module divisor_frc_multi
  import divisor_frc_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int CH = 2,
  parameter int DEFAULT_DIV = DIV_1HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic [CH-1:0] en,
  divisor_frc_multi_if.slave bus,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick
);
  logic accept;
  always_comb accept = bus.ld && bus.ld_div >= WIDTH'(MIN_DIV) && 32'(bus.ld_ch) < CH;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ld_ack <= 1'b0;
      bus.ld_err <= 1'b0;
    end else begin
      bus.ld_ack <= accept;
      bus.ld_err <= bus.ld && !accept;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    divisor_frc_ch #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .ld(accept && 32'(bus.ld_ch) == i),
      .ld_div(bus.ld_div),
      .clk_out(clk_out[i]),
      .tick(tick[i])
    );
  end
endmodule
